// File: rtl/cpu_alu_pkg.sv
// Shared opcode and flag types for the 8-bit 6502-style ALU.
// Build option: CPU_ALU_DECIMAL_EN enables BCD ADD/SUB in cpu_alu_core.
package cpu_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_AND    = 4'h2,
    ALU_OR     = 4'h3,
    ALU_XOR    = 4'h4,
    ALU_ASL    = 4'h5,
    ALU_LSR    = 4'h6,
    ALU_ROL    = 4'h7,
    ALU_ROR    = 4'h8,
    ALU_INC    = 4'h9,
    ALU_DEC    = 4'hA,
    ALU_PASS_A = 4'hB,
    ALU_BIT    = 4'hC,
    ALU_CMP    = 4'hD,
    ALU_PASS_B = 4'hE,
    ALU_RSVD   = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/cpu_alu_core.sv
// Combinational opcode/flag logic of the ALU.
// Build option: CPU_ALU_DECIMAL_EN adds BCD adjust to ADD/SUB when i_dec=1.
module cpu_alu_core
  import cpu_alu_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [3:0] i_op,
  input  logic       i_cin,
  input  logic       i_dec,
  output logic [7:0] o_result,
  output logic       o_c,
  output logic       o_v,
  output logic       o_n,
  output logic       o_z
);

  alu_op_e    w_op;
  logic [8:0] w_sum9;
  logic [7:0] w_res;
  alu_flags_t w_flags;

`ifdef CPU_ALU_DECIMAL_EN
  logic [5:0] w_lo;
  logic [5:0] w_hi;
  logic [4:0] w_nib;
`else
  logic       w_unused_dec;
  assign w_unused_dec = i_dec;
`endif

  assign w_op = alu_op_e'(i_op);

  always_comb begin
    w_sum9  = '0;
    w_res   = i_a;
    w_flags = '{c: i_cin, v: 1'b0, n: 1'b0, z: 1'b0};
`ifdef CPU_ALU_DECIMAL_EN
    w_lo  = '0;
    w_hi  = '0;
    w_nib = '0;
`endif
    case (w_op)
      ALU_ADD: begin
        w_sum9    = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
        w_res     = w_sum9[7:0];
        w_flags.c = w_sum9[8];
        w_flags.v = (i_a[7] == i_b[7]) && (w_sum9[7] != i_a[7]);
`ifdef CPU_ALU_DECIMAL_EN
        if (i_dec) begin
          w_lo = {2'b00, i_a[3:0]} + {2'b00, i_b[3:0]} + {5'd0, i_cin};
          if (w_lo > 6'd9) w_lo = w_lo + 6'd6;
          w_hi = {2'b00, i_a[7:4]} + {2'b00, i_b[7:4]} + {5'd0, (w_lo > 6'd15)};
          if (w_hi > 6'd9) w_hi = w_hi + 6'd6;
          w_flags.c = (w_hi > 6'd15);
          w_res     = {w_hi[3:0], w_lo[3:0]};
        end
`endif
      end
      ALU_SUB: begin
        w_sum9    = {1'b0, i_a} + {1'b0, ~i_b} + {8'd0, i_cin};
        w_res     = w_sum9[7:0];
        w_flags.c = w_sum9[8];
        w_flags.v = (i_a[7] != i_b[7]) && (w_sum9[7] != i_a[7]);
`ifdef CPU_ALU_DECIMAL_EN
        if (i_dec) begin
          // Nibble borrow == no carry out of the low-nibble A+~B+cin.
          w_nib = {1'b0, i_a[3:0]} + {1'b0, ~i_b[3:0]} + {4'd0, i_cin};
          if (!w_nib[4])    w_res = w_res - 8'h06;
          if (!w_sum9[8])   w_res = w_res - 8'h60;
        end
`endif
      end
      ALU_AND: w_res = i_a & i_b;
      ALU_OR:  w_res = i_a | i_b;
      ALU_XOR: w_res = i_a ^ i_b;
      ALU_ASL: begin
        w_res     = {i_a[6:0], 1'b0};
        w_flags.c = i_a[7];
      end
      ALU_LSR: begin
        w_res     = {1'b0, i_a[7:1]};
        w_flags.c = i_a[0];
      end
      ALU_ROL: begin
        w_res     = {i_a[6:0], i_cin};
        w_flags.c = i_a[7];
      end
      ALU_ROR: begin
        w_res     = {i_cin, i_a[7:1]};
        w_flags.c = i_a[0];
      end
      ALU_INC: w_res = i_a + 8'd1;
      ALU_DEC: w_res = i_a - 8'd1;
      ALU_BIT: begin
        w_res     = i_a & i_b;
        w_flags.v = i_b[6];
      end
      ALU_CMP: begin
        w_sum9    = {1'b0, i_a} + {1'b0, ~i_b} + 9'd1;
        w_res     = w_sum9[7:0];
        w_flags.c = w_sum9[8];
      end
      ALU_PASS_B: w_res = i_b;
      default:    w_res = i_a;
    endcase
    w_flags.n = (w_op == ALU_BIT) ? i_b[7] : w_res[7];
    w_flags.z = (w_res == 8'h00);
  end

  assign o_result = w_res;
  assign o_c      = w_flags.c;
  assign o_v      = w_flags.v;
  assign o_n      = w_flags.n;
  assign o_z      = w_flags.z;

endmodule

// File: rtl/cpu_alu.sv
// 8-bit ALU top: registers the core result/flags one cycle after in_valid.
// Build option: CPU_ALU_DECIMAL_EN (BCD ADD/SUB, see cpu_alu_core).
module cpu_alu
  import cpu_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  logic [3:0] operation,
  input  logic       carry_in,
  input  logic       decimal_in,
  output logic [7:0] result,
  output logic       carry_out,
  output logic       overflow,
  output logic       negative,
  output logic       zero,
  output logic       out_valid
);

  logic [7:0] w_result;
  alu_flags_t w_flags;
  logic [7:0] r_result;
  alu_flags_t r_flags;
  logic       r_valid;

  cpu_alu_core u_core (
    .i_a      (operand_a),
    .i_b      (operand_b),
    .i_op     (operation),
    .i_cin    (carry_in),
    .i_dec    (decimal_in),
    .o_result (w_result),
    .o_c      (w_flags.c),
    .o_v      (w_flags.v),
    .o_n      (w_flags.n),
    .o_z      (w_flags.z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result;
        r_flags  <= w_flags;
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_flags.c;
  assign overflow  = r_flags.v;
  assign negative  = r_flags.n;
  assign zero      = r_flags.z;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_cpu_alu.sv
// Self-checking bench for cpu_alu: directed vectors plus a reference model.
// Honours CPU_ALU_DECIMAL_EN the same way as the design.
module tb_cpu_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [3:0] operation;
  logic       carry_in;
  logic       decimal_in;
  logic [7:0] result;
  logic       carry_out, overflow, negative, zero, out_valid;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

`ifdef CPU_ALU_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .operation  (operation),
    .carry_in   (carry_in),
    .decimal_in (decimal_in),
    .result     (result),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .negative   (negative),
    .zero       (zero),
    .out_valid  (out_valid)
  );

  // Reference: {result, C, V, N, Z} from integer arithmetic.
  function automatic logic [11:0] model(int op, int a, int b, int cin, int dec);
    int r, c, v, n, z, sa, sb, s, lo, hi;
    c  = cin;
    v  = 0;
    r  = a;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin
        r = a + b + cin;
        c = (r > 255);
        s = sa + sb + cin;
        v = (s > 127 || s < -128);
        if (DEC_EN && dec != 0) begin
          lo = (a % 16) + (b % 16) + cin;
          if (lo > 9) lo += 6;
          hi = (a / 16) + (b / 16) + ((lo > 15) ? 1 : 0);
          if (hi > 9) hi += 6;
          c = (hi > 15);
          r = (hi % 16) * 16 + (lo % 16);
        end
      end
      1: begin
        r = a - b - (1 - cin);
        c = (r >= 0);
        s = sa - sb - (1 - cin);
        v = (s > 127 || s < -128);
        if (DEC_EN && dec != 0) begin
          if ((a % 16) - (b % 16) - (1 - cin) < 0) r -= 6;
          if (c == 0) r -= 96;
        end
      end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  begin r = a * 2;            c = (a > 127); end
      6:  begin r = a / 2;            c = a % 2;     end
      7:  begin r = a * 2 + cin;      c = (a > 127); end
      8:  begin r = cin * 128 + a / 2; c = a % 2;    end
      9:  r = a + 1;
      10: r = a - 1;
      12: r = a & b;
      13: begin r = a - b; c = (a >= b); end
      14: r = b;
      default: r = a;
    endcase
    r = r & 255;
    n = (r > 127);
    z = (r == 0);
    if (op == 12) begin
      n = (b > 127);
      v = (b / 64) % 2;
    end
    model = {r[7:0], c[0], v[0], n[0], z[0]};
  endfunction

  logic [11:0] m_out;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out   <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid)
        m_out <= model(int'(operation), int'(operand_a), int'(operand_b),
                       int'(carry_in), int'(decimal_in));
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp && rst_n)
      check("model", {3'd0, result, carry_out, overflow, negative, zero, out_valid},
            {3'd0, m_out, m_valid});
  end

  task automatic apply(string name, logic [3:0] op, logic [7:0] a, logic [7:0] b,
                       logic cin, logic dec, logic [7:0] r,
                       logic c, logic v, logic n, logic z);
    @(negedge clk);
    in_valid   = 1'b1;
    operation  = op;
    operand_a  = a;
    operand_b  = b;
    carry_in   = cin;
    decimal_in = dec;
    @(posedge clk);
    #1;
    check(name, {3'd0, result, carry_out, overflow, negative, zero, out_valid},
          {3'd0, r, c, v, n, z, 1'b1});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; operation = '0;
    operand_a = '0; operand_b = '0; carry_in = 1'b0; decimal_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {3'd0, result, carry_out, overflow, negative, zero, out_valid}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", {15'd0, out_valid}, 16'h0);
    run_cmp = 1'b1;

    //          name        op    A      B      cin dec  R      C V N Z
    apply("add_ovf",   4'h0, 8'h50, 8'h30, 0, 0, 8'h80, 0, 1, 1, 0);
    apply("add_wrap",  4'h0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 0, 1);
    apply("sub_nb",    4'h1, 8'h80, 8'h30, 1, 0, 8'h50, 1, 1, 0, 0);
    apply("sub_borrow",4'h1, 8'h30, 8'h80, 1, 0, 8'hB0, 0, 1, 1, 0);
    apply("cmp_eq",    4'hD, 8'h50, 8'h50, 0, 0, 8'h00, 1, 0, 0, 1);
    apply("and",       4'h2, 8'hF0, 8'h0F, 0, 0, 8'h00, 0, 0, 0, 1);
    apply("or",        4'h3, 8'hF0, 8'h0F, 0, 0, 8'hFF, 0, 0, 1, 0);
    apply("xor",       4'h4, 8'hAA, 8'h55, 1, 0, 8'hFF, 1, 0, 1, 0);
    apply("bit",       4'hC, 8'h0F, 8'hC0, 0, 0, 8'h00, 0, 1, 1, 1);
    apply("asl",       4'h5, 8'h81, 8'h00, 0, 0, 8'h02, 1, 0, 0, 0);
    apply("lsr",       4'h6, 8'h81, 8'h00, 0, 0, 8'h40, 1, 0, 0, 0);
    apply("rol",       4'h7, 8'h81, 8'h00, 1, 0, 8'h03, 1, 0, 0, 0);
    apply("ror",       4'h8, 8'h81, 8'h00, 1, 0, 8'hC0, 1, 0, 1, 0);
    apply("inc",       4'h9, 8'hFE, 8'h00, 0, 0, 8'hFF, 0, 0, 1, 0);
    apply("dec",       4'hA, 8'h01, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    apply("inc_wrap",  4'h9, 8'hFF, 8'h00, 1, 0, 8'h00, 1, 0, 0, 1);
    apply("dec_wrap",  4'hA, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 0, 1, 0);
    apply("pass_a",    4'hB, 8'h7F, 8'h80, 1, 0, 8'h7F, 1, 0, 0, 0);
    apply("pass_b",    4'hE, 8'h00, 8'h80, 0, 0, 8'h80, 0, 0, 1, 0);
    apply("cmp_lt",    4'hD, 8'h10, 8'h20, 1, 0, 8'hF0, 0, 0, 1, 0);
`ifdef CPU_ALU_DECIMAL_EN
    apply("bcd_add",   4'h0, 8'h09, 8'h01, 0, 1, 8'h10, 0, 0, 0, 0);
    apply("bcd_wrap",  4'h0, 8'h99, 8'h01, 0, 1, 8'h00, 1, 0, 0, 1);
`else
    apply("dec_ignored", 4'h0, 8'h09, 8'h01, 0, 1, 8'h0A, 0, 0, 0, 0);
`endif
    apply("rsvd",      4'hF, 8'h00, 8'h55, 0, 0, 8'h00, 0, 0, 0, 1);

    @(negedge clk);
    in_valid = 1'b0;
    operation = 4'h3; operand_a = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("hold", {3'd0, result, carry_out, overflow, negative, zero, out_valid},
          {3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    apply("pre_reset", 4'h0, 8'h50, 8'h30, 0, 0, 8'h80, 0, 1, 1, 0);
    @(negedge clk);
    in_valid = 1'b1; operation = 4'hB; operand_a = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {3'd0, result, carry_out, overflow, negative, zero, out_valid}, 16'h0);
    @(posedge clk);
    #1;
    check("reset_discard", {3'd0, result, carry_out, overflow, negative, zero, out_valid}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", {15'd0, out_valid}, 16'h0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(3) != 0);
      operation  = 4'($urandom_range(15));
      operand_a  = 8'($urandom_range(255));
      operand_b  = 8'($urandom_range(255));
      carry_in   = 1'($urandom_range(1));
      decimal_in = 1'($urandom_range(1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_alu.md
Name: cpu_alu

Overview:
8-bit 6502-style ALU with registered outputs, sitting between the CPU decoder/operand muxes and the accumulator/status register. It performs add/subtract with carry, logic, shifts/rotates, increment/decrement, compare and BIT-test. It produces the result plus the C, V, N and Z flags one clock after a valid request.

Parameters:
none (width fixed at 8; opcode encoding fixed in cpu_alu_pkg)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/operation valid this cycle
operand_a  input  8  A operand (accumulator or memory value for shifts/INC/DEC)
operand_b  input  8  B operand
operation  input  4  opcode (see Behaviour)
carry_in  input  1  current C flag
decimal_in  input  1  current D flag; used only with CPU_ALU_DECIMAL_EN
result  output  8  registered result
carry_out  output  1  registered C
overflow  output  1  registered V
negative  output  1  registered N
zero  output  1  registered Z
out_valid  output  1  high exactly one cycle after an in_valid cycle

Behaviour:
- Reset: asynchronous on rst_n low. result=0x00; carry_out, overflow, negative, zero and out_valid all 0.
- Latency is 1 cycle. On a rising clk edge with in_valid=1, all outputs load from the combinational core and out_valid=1.
- On a rising clk edge with in_valid=0, outputs hold their values and out_valid=0.
- No backpressure.
- Default flags: N=result[7]; Z=(result==0).
- Default C=carry_in (passed through unchanged).
- Default V=0.
- 0000 ADD (ADC): sum9=A+B+cin; result=sum9[7:0]; C=sum9[8]; V=(A7==B7)&&(R7!=A7).
- 0001 SUB (SBC): computed as A+~B+cin; C=1 means no borrow; V=(A7!=B7)&&(R7!=A7).
- 0010 AND: A&B.
- 0011 OR: A|B.
- 0100 XOR: A^B.
- 0101 ASL: {A[6:0],0}; C=A7.
- 0110 LSR: {0,A[7:1]}; C=A0; N is therefore 0.
- 0111 ROL: {A[6:0],cin}; C=A7.
- 1000 ROR: {cin,A[7:1]}; C=A0.
- 1001 INC: A+1 mod 256; C=cin.
- 1010 DEC: A-1 mod 256; C=cin.
- 1011 PASS_A: result=A.
- 1100 BIT: result=A&B; Z=((A&B)==0); N=B7; V=B6; C=cin.
- 1101 CMP: result=A-B (carry forced to 1, carry_in ignored); C=(A>=B unsigned); V=0.
- 1110 PASS_B: result=B.
- 1111 reserved: behaves as PASS_A.
- Wrap-around: INC 0xFF→0x00 (Z=1); DEC 0x00→0xFF (N=1). Carry is unaffected in both cases.
- Reset asserted mid-operation discards the pending request; out_valid stays 0.

Optional Feature:
CPU_ALU_DECIMAL_EN.

When defined and decimal_in=1, ADD and SUB operate in BCD:
- ADD: lo=A[3:0]+B[3:0]+cin; if lo>9, lo+=6. hi=A[7:4]+B[7:4]+(lo>15); if hi>9, hi+=6. C=(hi>15).
- SUB: take the binary difference. Subtract 0x06 if the low nibble borrowed. Subtract 0x60 if C=0.
- Flags: N and Z come from the corrected result. V comes from the binary computation.

When not defined, decimal_in is ignored and ADD/SUB are always binary. The port remains present in both builds.

Decomposition:
- cpu_alu_pkg: alu_op_e enum with the 4-bit opcodes listed in Behaviour, and an alu_flags_t struct {c,v,n,z}.
- One sub-module, cpu_alu_core: purely combinational opcode/flag logic, including the BCD adjust under the macro.
- cpu_alu itself holds only the output registers and out_valid.

Test Plan:
- Reset: drive rst_n=0 mid-stream → all outputs 0 immediately, out_valid=0. Release reset; out_valid stays 0 until the first in_valid.
- ADD 0x50+0x30, cin=0 → 0x80, N=1 Z=0 C=0 V=1. ADD 0xFF+0x01, cin=0 → 0x00, Z=1 C=1.
- SUB 0x80-0x30, cin=1 → 0x50, C=1. SUB 0x30-0x80, cin=1 → 0xB0, C=0. CMP 0x50,0x50, cin=0 → 0x00, Z=1 C=1.
- AND 0xF0&0x0F → 0x00, Z=1. OR → 0xFF, N=1. XOR 0xAA^0x55 → 0xFF. BIT A=0x0F, B=0xC0 → Z=1 N=1 V=1.
- Shifts on A=0x81: ASL → 0x02, C=1. LSR → 0x40, C=1. ROL with cin=1 → 0x03, C=1. ROR with cin=1 → 0xC0, C=1.
- INC 0xFE, cin=0 → 0xFF, C=0. DEC 0x01 → 0x00, Z=1, C=0. With in_valid=0, outputs hold.
- With the macro defined and D=1: ADD 0x09+0x01 → 0x10, C=0. ADD 0x99+0x01 → 0x00, C=1.
